// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions: Q8.12 format constants and the state encoding
// used by the iterative arithmetic blocks.
package fixed_pkg;

  localparam int unsigned Q_W    = 20;
  localparam int unsigned Q_FRAC = 12;

  localparam logic [Q_W-1:0] Q_MAX = 20'h7FFFF;
  localparam logic [Q_W-1:0] Q_MIN = 20'h80000;
  localparam logic [Q_W-1:0] Q_ONE = 20'h01000;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } iter_state_e;

  // Magnitude of a two's complement value; the most negative value maps to 2^(Q_W-1).
  function automatic logic [Q_W-1:0] q_abs(input logic [Q_W-1:0] x);
    return x[Q_W-1] ? -x : x;
  endfunction

endpackage

// File: rtl/fixed_div_core.sv
// Radix-2 restoring division datapath: one quotient bit per step strobe, MSB first.
// Operates on unsigned magnitudes; signs and saturation are handled by the caller.
module fixed_div_core
  import fixed_pkg::*;
#(
  parameter int unsigned W    = Q_W,
  parameter int unsigned FRAC = Q_FRAC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [W-1:0]       dvd_mag,
  input  logic [W-1:0]       dvs_mag,
  output logic [W+FRAC-1:0]  quot
);

  localparam int unsigned N = W + FRAC;

  logic [N-1:0] dvd_q;
  logic [N-1:0] quot_q;
  logic [W:0]   rem_q;
  logic [W-1:0] dvs_q;

  logic [W:0]   rem_sh;
  logic [W:0]   rem_d;
  logic         qbit;

  always_comb begin
    rem_sh = {rem_q[W-1:0], dvd_q[N-1]};
    qbit   = (rem_sh >= {1'b0, dvs_q});
    rem_d  = qbit ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dvd_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (load) begin
      dvd_q  <= {dvd_mag, {FRAC{1'b0}}};
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= dvs_mag;
    end else if (step) begin
      dvd_q  <= {dvd_q[N-2:0], 1'b0};
      quot_q <= {quot_q[N-2:0], qbit};
      rem_q  <= rem_d;
    end
  end

  assign quot = quot_q;

endmodule

// File: rtl/fixed_div.sv
// Sequential signed Q8.12 divider with start/done handshake, saturation and
// divide-by-zero flagging. Fixed latency regardless of operands.
module fixed_div
  import fixed_pkg::*;
#(
  parameter int unsigned W    = Q_W,
  parameter int unsigned FRAC = Q_FRAC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] out,
  output logic         ovf,
  output logic         dz
);

  localparam int unsigned N  = W + FRAC;
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [W-1:0] SatMax = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SatMin = {1'b1, {(W-1){1'b0}}};

  iter_state_e state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic          sa_q, sb_q, bz_q;
  logic [W-1:0]  out_q;
  logic          ovf_q, dz_q;

  logic          load, step, last;
  logic [W-1:0]  mag_a, mag_b;
  logic [N-1:0]  quot;
  logic          neg;
  logic [W-1:0]  res;
  logic          res_ovf, res_dz;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == CW'(N)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // One extra RUN cycle after the last step registers the saturated result.
  always_comb begin
    ready = (state_q == StIdle);
    done  = (state_q == StDone);
    load  = ready && start;
    step  = (state_q == StRun) && (cnt_q != CW'(N));
    last  = (state_q == StRun) && (cnt_q == CW'(N));
  end

  always_comb begin
    mag_a = A[W-1] ? -A : A;
    mag_b = B[W-1] ? -B : B;
  end

  fixed_div_core #(
    .W    (W),
    .FRAC (FRAC)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .dvd_mag (mag_a),
    .dvs_mag (mag_b),
    .quot    (quot)
  );

  always_comb begin
    neg     = sa_q ^ sb_q;
    res     = '0;
    res_ovf = 1'b0;
    res_dz  = 1'b0;
    if (bz_q) begin
      res    = sa_q ? SatMin : SatMax;
      res_dz = 1'b1;
    end else if (!neg && (quot > {{FRAC{1'b0}}, SatMax})) begin
      res     = SatMax;
      res_ovf = 1'b1;
    end else if (neg && (quot > {{FRAC{1'b0}}, SatMin})) begin
      res     = SatMin;
      res_ovf = 1'b1;
    end else begin
      // Negating a zero quotient yields +0, so no special case is needed.
      res = neg ? -quot[W-1:0] : quot[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      bz_q  <= 1'b0;
      out_q <= '0;
      ovf_q <= 1'b0;
      dz_q  <= 1'b0;
    end else begin
      if (load) begin
        cnt_q <= '0;
        sa_q  <= A[W-1];
        sb_q  <= B[W-1];
        bz_q  <= (B == '0);
      end else if (step) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (last) begin
        out_q <= res;
        ovf_q <= res_ovf;
        dz_q  <= res_dz;
      end
    end
  end

  assign out = out_q;
  assign ovf = ovf_q;
  assign dz  = dz_q;

endmodule
